// File: rtl/muldiv_pkg.sv
// Shared types and op encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULTU = 2'b00,
        MULT  = 2'b01,
        DIVU  = 2'b10,
        DIV   = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FIXUP = 2'b10
    } muldiv_state_t;

    // Encodings the controller decoder drives onto op_i.
    localparam logic [1:0] MULDIV_OP_MULTU = 2'b00;
    localparam logic [1:0] MULDIV_OP_MULT  = 2'b01;
    localparam logic [1:0] MULDIV_OP_DIVU  = 2'b10;
    localparam logic [1:0] MULDIV_OP_DIV   = 2'b11;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Two's-complement conditional negate: magnitude at operand capture, sign restore at fixup.
module muldiv_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 MULT/MULTU/DIV/DIVU with HI/LO; latency WIDTH+2.
// MULDIV_EARLY_OUT_EN: multiply exits RUN once the remaining multiplier bits are zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t      state_q;
    logic [CW-1:0]      cnt_q;
    logic               fix_ph_q;
    logic               div_q;
    logic               neg_res_q, neg_rem_q, dbz_q;
    logic [2*WIDTH-1:0] mcand_q, acc_q;
    logic [WIDTH-1:0]   mplier_q, rem_q, quo_q, dvs_q, a_raw_q;
    logic               busy_q, done_q, dbz_out_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    muldiv_op_t       op_in;
    logic             in_signed;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_in     = muldiv_op_t'(op_i);
    assign in_signed = op_is_signed(op_in);

    muldiv_abs #(.W(WIDTH)) u_cap_a (.val_i(a_i), .neg_i(in_signed & a_i[WIDTH-1]), .res_o(a_mag));
    muldiv_abs #(.W(WIDTH)) u_cap_b (.val_i(b_i), .neg_i(in_signed & b_i[WIDTH-1]), .res_o(b_mag));

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    muldiv_abs #(.W(2*WIDTH)) u_fix_p (.val_i(acc_q), .neg_i(neg_res_q), .res_o(prod_fix));
    muldiv_abs #(.W(WIDTH))   u_fix_q (.val_i(quo_q), .neg_i(neg_res_q), .res_o(quo_fix));
    muldiv_abs #(.W(WIDTH))   u_fix_r (.val_i(rem_q), .neg_i(neg_rem_q), .res_o(rem_fix));

    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_d;
    logic [WIDTH:0]     rem_sh, diff;
    logic               last_iter, run_exit;

    // Multiplicand shifts left so an early exit leaves the product already aligned.
    assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mplier_d  = mplier_q >> 1;
    assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
    assign diff      = rem_sh - {1'b0, dvs_q};
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
    assign run_exit = last_iter | (!div_q && (mplier_d == '0));
`else
    assign run_exit = last_iter;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fix_ph_q  <= 1'b0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            a_raw_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_hi_i) hi_q <= wr_data_i;
                    if (wr_lo_i) lo_q <= wr_data_i;
                    if (start_i) begin
                        div_q     <= op_is_div(op_in);
                        neg_res_q <= in_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        neg_rem_q <= in_signed & a_i[WIDTH-1];
                        dbz_q     <= op_is_div(op_in) && (b_i == '0);
                        mcand_q   <= {{WIDTH{1'b0}}, a_mag};
                        mplier_q  <= b_mag;
                        acc_q     <= '0;
                        rem_q     <= '0;
                        quo_q     <= a_mag;
                        dvs_q     <= b_mag;
                        a_raw_q   <= a_i;
                        cnt_q     <= '0;
                        fix_ph_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (div_q) begin
                        rem_q <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                        mplier_q <= mplier_d;
                    end
                    if (run_exit) state_q <= FIXUP;
                end
                FIXUP: begin
                    // Phase 0 registers the sign correction, phase 1 commits HI/LO.
                    if (!fix_ph_q) begin
                        fix_ph_q <= 1'b1;
                        if (div_q) begin
                            quo_q <= quo_fix;
                            rem_q <= rem_fix;
                        end else begin
                            acc_q <= prod_fix;
                        end
                    end else begin
                        if (!div_q) begin
                            hi_q <= acc_q[2*WIDTH-1:WIDTH];
                            lo_q <= acc_q[WIDTH-1:0];
                        end else if (dbz_q) begin
                            hi_q <= a_raw_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_q;
                            lo_q <= quo_q;
                        end
                        done_q    <= 1'b1;
                        dbz_out_q <= dbz_q;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_out_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, wr_hi, wr_lo;
    logic [1:0]   op;
    logic [W-1:0] a, b, wr_data;
    logic         busy, done, dbz;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] m_hi, m_lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .wr_hi_i(wr_hi), .wr_lo_i(wr_lo), .wr_data_i(wr_data),
        .busy_o(busy), .done_o(done), .div_by_zero_o(dbz), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // kind: 0 plain, 1 start during busy, 2 writes during busy, 4 wr_lo with start
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int kind, input logic [W-1:0] d);
        logic [W-1:0] ehi, elo;
        logic         edbz;
        logic [63:0]  p;
        int           sa, sb, n;
        edbz = 1'b0;
        if (!o[1]) begin
            if (o[0]) p = 64'(longint'($signed(av)) * longint'($signed(bv)));
            else      p = {32'b0, av} * {32'b0, bv};
            ehi = p[63:32];
            elo = p[31:0];
        end else if (bv == '0) begin
            elo = '1; ehi = av; edbz = 1'b1;
        end else if (o[0]) begin
            sa = $signed(av);
            sb = $signed(bv);
            if (sa == int'(32'h8000_0000) && sb == -1) begin
                elo = 32'h8000_0000; ehi = '0;
            end else begin
                elo = 32'(sa / sb); ehi = 32'(sa % sb);
            end
        end else begin
            elo = av / bv; ehi = av % bv;
        end

        op = o; a = av; b = bv; start = 1'b1;
        if (kind == 4) begin wr_lo = 1'b1; wr_data = d; end
        @(posedge clk); #1;
        start = 1'b0; wr_lo = 1'b0;
        if (kind == 4) begin
            m_lo = d;
            chk("wr_lo_with_start", {32'b0, lo}, {32'b0, m_lo});
        end
        chk("busy_after_start", {63'b0, busy}, 64'd1);
        n = 0;
        for (int i = 0; i < W + 10; i++) begin
            if (kind == 1 && n == 5) begin start = 1'b1; op = ~o; a = ~av; b = bv + 1; end
            if (kind == 2 && n == 5) begin wr_lo = 1'b1; wr_hi = 1'b1; wr_data = d; end
            @(posedge clk); #1;
            n++;
            start = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
            if (kind == 2 && n == 6) begin
                chk("wr_lo_busy_ignored", {32'b0, lo}, {32'b0, m_lo});
                chk("wr_hi_busy_ignored", {32'b0, hi}, {32'b0, m_hi});
            end
            if (done) break;
        end
        chk("latency", 64'(n), 64'(W + 2));
        chk("hi", {32'b0, hi}, {32'b0, ehi});
        chk("lo", {32'b0, lo}, {32'b0, elo});
        chk("div_by_zero", {63'b0, dbz}, {63'b0, edbz});
        chk("busy_at_done", {63'b0, busy}, 64'd0);
        m_hi = ehi; m_lo = elo;
        if (kind == 1) begin
            @(posedge clk); #1;
            chk("no_queued_start", {63'b0, busy}, 64'd0);
            chk("done_one_cycle", {63'b0, done}, 64'd0);
        end
    endtask

    initial begin
        int seen;
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op = '0; a = '0; b = '0; wr_data = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_dbz",  {63'b0, dbz},  64'd0);
        chk("rst_hi",   {32'b0, hi},   64'd0);
        chk("rst_lo",   {32'b0, lo},   64'd0);
        reset = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0);
        chk("multu_max_hi", {32'b0, hi}, 64'h0000_0000_FFFF_FFFE);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0, '0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, '0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, '0);
        run_op(2'b10, 32'd100, 32'd0, 0, '0);
        run_op(2'b11, 32'hFFFF_FFF0, 32'd0, 0, '0);

        @(posedge clk); #1;
        chk("dbz_one_cycle", {63'b0, dbz}, 64'd0);
        wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        wr_hi = 1'b0; m_hi = 32'hDEAD_BEEF;
        chk("mthi_idle", {32'b0, hi}, {32'b0, m_hi});
        wr_lo = 1'b1; wr_data = 32'h1234_5678;
        @(posedge clk); #1;
        wr_lo = 1'b0; m_lo = 32'h1234_5678;
        chk("mtlo_idle", {32'b0, lo}, {32'b0, m_lo});

        run_op(2'b00, 32'd3, 32'd4, 4, 32'hCAFE_F00D);
        run_op(2'b10, 32'd1000, 32'd7, 1, '0);
        run_op(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 2, 32'h5555_AAAA);

        // reset in the middle of an operation
        op = 2'b11; a = 32'hFFFF_0000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_hi", {32'b0, hi}, 64'd0);
        chk("midrst_lo", {32'b0, lo}, 64'd0);
        m_hi = '0; m_lo = '0;
        seen = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("midrst_no_done", 64'(seen), 64'd0);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
